product_accumulator: RTL

Sequential stage directly downstream of the 4-bit array multiplier. It takes the multiplier's 8-bit product P through a valid/ready handshake and sums a frame of LEN products into a saturating accumulator. It then presents the frame total through a second valid/ready handshake. It is the accumulate half of the team's multiply-accumulate datapath.

---
 rtl/product_accumulator.sv | 86 ++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Accumulates frames of LEN unsigned 8-bit products into a saturating sum and
// hands the frame total downstream over a valid/ready handshake.
module product_accumulator #(
  parameter int ACC_WIDTH = 16,
  parameter int LEN       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           p_in,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 sat
);

  localparam int CW = $clog2(LEN + 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
  localparam logic [CW-1:0]        LAST    = CW'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [CW-1:0]        cnt_q;
  logic                 sat_q;
  logic                 sat_d;
  logic                 out_valid_q;
  logic [ACC_WIDTH:0]   sum;
  logic                 accept;

  assign in_ready = (state_q == ACCUM) && !rst;
  assign accept   = in_valid && in_ready;

  // One extra bit catches the carry out; a saturated acc stays at max since max+p always carries or equals max.
  always_comb begin
    sum   = {1'b0, acc_q} + {{(ACC_WIDTH - 7){1'b0}}, p_in};
    acc_d = sum[ACC_WIDTH] ? ACC_MAX : sum[ACC_WIDTH-1:0];
    sat_d = sat_q | sum[ACC_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            sat_q <= sat_d;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign acc_out   = acc_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;

endmodule
